// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
// Shared types and defaults for the two-master AHB-lite arbiter.
//   own_e         : which master (if any) owns the address phase
//   *_DEF         : default widths and burst limit used by the top level
//   burst_cnt_w() : width needed to count 0..max_burst inclusive
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } own_e;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int MAX_BURST_DEF = 8;

   function automatic int burst_cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/ahb_arb_rr.sv
// ---------------------------------------------------------------------------
// ahb_arb_rr
// Combinational next-owner selection for the two-master arbiter.
// Ports:
//   req[1:0]   in  : level bus requests {m1, m0}
//   owner      in  : current address-phase owner
//   rr_last    in  : master served most recently (loses a tie)
//   burst_full in  : current owner has used up its burst allowance
//   next_owner out : owner to take effect at the next arbitration edge
// ---------------------------------------------------------------------------
module ahb_arb_rr
   import ahb_arb_pkg::*;
(
   input  logic [1:0] req,
   input  own_e       owner,
   input  own_e       rr_last,
   input  logic       burst_full,
   output own_e       next_owner
);

   // An owner keeps the bus while it requests, unless its burst allowance is
   // spent and the other master is waiting. From idle, a tie goes to the
   // master that was not served last.
   always_comb begin
      next_owner = OWN_NONE;
      case (owner)
         OWN_M0: begin
            if (req[0] && !(burst_full && req[1])) begin
               next_owner = OWN_M0;
            end else if (req[1]) begin
               next_owner = OWN_M1;
            end
         end
         OWN_M1: begin
            if (req[1] && !(burst_full && req[0])) begin
               next_owner = OWN_M1;
            end else if (req[0]) begin
               next_owner = OWN_M0;
            end
         end
         default: begin
            if (req == 2'b11) begin
               next_owner = (rr_last == OWN_M0) ? OWN_M1 : OWN_M0;
            end else if (req[0]) begin
               next_owner = OWN_M0;
            end else if (req[1]) begin
               next_owner = OWN_M1;
            end
         end
      endcase
   end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
// Shares one AHB-lite master port between M0 (LSU) and M1 (fetch/DMA) with
// round-robin ownership and a per-owner burst limit. Address phase is muxed
// by the address owner, write data by the data-phase owner, and error
// responses are routed to the data-phase owner only.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   m{0,1}_hbusreq/haddr/haddr_ctrl/hwrite/hwdata : master request side
//   m{0,1}_hgrant                    : master owns the address phase
//   m{0,1}_hresp                     : error response for the data-phase owner
//   hready_s2m, hdata_s2m            : broadcast ready / read data
//   hbusreq_m2h, hgrant_h2m          : fabric request / grant
//   haddr_m2h, haddr_ctrl_m2h, hwrite_m2h, hwdata_m2h : muxed fabric side
//   hready, hresp, hrdata            : fabric response
// ---------------------------------------------------------------------------
module ahb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_hbusreq,
   input  logic [ADDR_W-1:0] m0_haddr,
   input  logic              m0_haddr_ctrl,
   input  logic              m0_hwrite,
   input  logic [DATA_W-1:0] m0_hwdata,
   input  logic              m1_hbusreq,
   input  logic [ADDR_W-1:0] m1_haddr,
   input  logic              m1_haddr_ctrl,
   input  logic              m1_hwrite,
   input  logic [DATA_W-1:0] m1_hwdata,
   output logic              m0_hgrant,
   output logic              m1_hgrant,
   output logic              m0_hresp,
   output logic              m1_hresp,
   output logic              hready_s2m,
   output logic [DATA_W-1:0] hdata_s2m,
   output logic              hbusreq_m2h,
   input  logic              hgrant_h2m,
   output logic [ADDR_W-1:0] haddr_m2h,
   output logic              haddr_ctrl_m2h,
   output logic              hwrite_m2h,
   output logic [DATA_W-1:0] hwdata_m2h,
   input  logic              hready,
   input  logic              hresp,
   input  logic [DATA_W-1:0] hrdata
);

   localparam int                CNT_W      = burst_cnt_w(MAX_BURST);
   localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]  MAX_CNT_M1 = CNT_W'(MAX_BURST - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   own_e             owner;
   own_e             next_owner;
   own_e             rr_last;
   own_e             dp_owner;
   logic             dp_vld;
   logic [CNT_W-1:0] burst_cnt;
   logic             accept;
   logic             burst_full;

   assign accept = haddr_ctrl_m2h & hready & hgrant_h2m;

   // The allowance counts the accept happening on this edge, so the owner is
   // released right after its MAX_BURST-th accepted address phase and the
   // next master's address overlaps that last data phase.
   assign burst_full = (burst_cnt == MAX_CNT) | (accept & (burst_cnt == MAX_CNT_M1));

   ahb_arb_rr u_rr (
      .req        ({m1_hbusreq, m0_hbusreq}),
      .owner      (owner),
      .rr_last    (rr_last),
      .burst_full (burst_full),
      .next_owner (next_owner)
   );

   // Ownership, burst counter and data-phase tracking. The data phase ends on
   // any cycle with hready high; ownership only moves when the fabric is
   // ready and grants us. rr_last only remembers real masters so an idle gap
   // does not forget who was served last.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_NONE;
         rr_last   <= OWN_M1;
         dp_owner  <= OWN_NONE;
         dp_vld    <= 1'b0;
         burst_cnt <= '0;
      end else begin
         if (accept) begin
            dp_vld   <= 1'b1;
            dp_owner <= owner;
         end else if (hready) begin
            dp_vld <= 1'b0;
         end
         if (hready && hgrant_h2m) begin
            if (next_owner != owner) begin
               owner     <= next_owner;
               burst_cnt <= '0;
               if (owner != OWN_NONE) begin
                  rr_last <= owner;
               end
            end else if (accept && (burst_cnt != MAX_CNT)) begin
               burst_cnt <= burst_cnt + CNT_ONE;
            end
         end
      end
   end

   // Address phase follows the owner; with no owner the bus is driven idle.
   always_comb begin
      haddr_m2h      = '0;
      haddr_ctrl_m2h = 1'b0;
      hwrite_m2h     = 1'b0;
      case (owner)
         OWN_M0: begin
            haddr_m2h      = m0_haddr;
            haddr_ctrl_m2h = m0_haddr_ctrl;
            hwrite_m2h     = m0_hwrite;
         end
         OWN_M1: begin
            haddr_m2h      = m1_haddr;
            haddr_ctrl_m2h = m1_haddr_ctrl;
            hwrite_m2h     = m1_hwrite;
         end
         default: ;
      endcase
   end

   // Write data follows the data-phase owner, which can differ from the
   // address owner right after a handover.
   always_comb begin
      hwdata_m2h = '0;
      if (dp_vld) begin
         case (dp_owner)
            OWN_M0:  hwdata_m2h = m0_hwdata;
            OWN_M1:  hwdata_m2h = m1_hwdata;
            default: hwdata_m2h = '0;
         endcase
      end
   end

   assign m0_hgrant   = (owner == OWN_M0);
   assign m1_hgrant   = (owner == OWN_M1);
   assign m0_hresp    = hresp & dp_vld & (dp_owner == OWN_M0);
   assign m1_hresp    = hresp & dp_vld & (dp_owner == OWN_M1);
   assign hready_s2m  = hready;
   assign hdata_s2m   = hrdata;
   assign hbusreq_m2h = m0_hbusreq | m1_hbusreq;

endmodule
